// File: rtl/tx_buffer.sv
// tx_buffer: captures one sorted array in a single cycle and streams it byte-wise to a UART
// transmitter over a start/busy handshake, optionally followed by an end-of-array marker.
module tx_buffer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter bit          SEND_END = 1'b1,
  parameter logic [7:0]  END_BYTE = 8'h0A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [0:WIDTH-1] array_in [DEPTH],
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic             ready,
  output logic             done,
  output logic             dropped
);

  if (WIDTH % 8 != 0) begin : g_width_check
    $error("tx_buffer: WIDTH must be a multiple of 8");
  end

  localparam int unsigned BPW = WIDTH / 8;
  localparam int unsigned BiW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned EiW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BiW-1:0] ByteLast = BiW'(BPW - 1);
  localparam logic [EiW-1:0] ElemLast = EiW'(DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitAck,
    StWaitDone,
    StEnd,
    StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [BiW-1:0]   byte_q, byte_d;
  logic [EiW-1:0]   elem_q, elem_d;
  logic [1:0]       ack_q, ack_d;      // cycles spent waiting for tx_busy to rise
  logic             end_q, end_d;      // current byte is the end marker
  logic             dropped_q;
  logic             capture;
  logic [0:WIDTH-1] array_q [DEPTH];

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      byte_q  <= '0;
      elem_q  <= '0;
      ack_q   <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      elem_q  <= elem_d;
      ack_q   <= ack_d;
      end_q   <= end_d;
    end
  end

  // Capture register: loaded only on an accepted valid_in, so later array_in changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        array_q[i] <= '0;
      end
    end else if (capture) begin
      array_q <= array_in;
    end
  end

  // Flag a valid_in that arrives while a transfer is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= valid_in && (state_q != StIdle);
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    elem_d   = elem_q;
    ack_d    = ack_q;
    end_d    = end_q;
    capture  = 1'b0;
    tx_start = 1'b0;
    ready    = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (valid_in) begin
          capture = 1'b1;
          byte_d  = '0;
          elem_d  = '0;
          end_d   = 1'b0;
          state_d = StSend;
        end
      end
      StSend, StEnd: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          ack_d    = '0;
          state_d  = StWaitAck;
        end
      end
      StWaitAck: begin
        // Give up waiting after four cycles so a missed busy pulse cannot hang the buffer.
        if (tx_busy || ack_q == 2'd3) begin
          state_d = StWaitDone;
        end else begin
          ack_d = ack_q + 2'd1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (end_q) begin
            state_d = StFinish;
          end else if (elem_q == ElemLast && byte_q == ByteLast) begin
            if (SEND_END) begin
              end_d   = 1'b1;
              state_d = StEnd;
            end else begin
              state_d = StFinish;
            end
          end else begin
            if (byte_q == ByteLast) begin
              byte_d = '0;
              elem_d = elem_q + 1'b1;
            end else begin
              byte_d = byte_q + 1'b1;
            end
            state_d = StSend;
          end
        end
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte mux: element index selects the word, byte index walks from bit 0 (the MSB) down.
  always_comb begin
    tx_data = 8'h00;
    if (state_q != StIdle) begin
      if (end_q) begin
        tx_data = END_BYTE;
      end else begin
        tx_data = array_q[elem_q][{byte_q, 3'b000} +: 8];
      end
    end
  end

  assign dropped = dropped_q;

endmodule
